// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter with start/busy/done handshake.
// Define BCD_SEG_EN to add the registered 7-segment output seg_out.
module bin2bcd_seq #(
    parameter int IN_W   = 7,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
`ifdef BCD_SEG_EN
    ,
    output logic [7*DIGITS-1:0]   seg_out
`endif
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t              state, state_nxt;
    logic [IN_W-1:0]     binreg;
    logic [BCD_W-1:0]    scratch;
    logic [BCD_W-1:0]    scratch_adj;
    logic [BCD_W+IN_W-1:0] shift_full;
    logic [CNT_W-1:0]    cnt;
    logic                accept;
    logic                last;

    // Handshake outputs are pure state decodes, so busy and done are mutually exclusive.
    assign busy   = (state == S_SHIFT);
    assign done   = (state == S_DONE);
    assign accept = start && (state != S_SHIFT);
    assign last   = (state == S_SHIFT) && (cnt == CNT_W'(IN_W - 1));

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
        shift_full = {scratch_adj, binreg} << 1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_SHIFT;
            S_SHIFT: if (last)  state_nxt = S_DONE;
            S_DONE:  state_nxt = start ? S_SHIFT : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

`ifdef BCD_SEG_EN
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0111111;
            4'd1:    seg7 = 7'b0000110;
            4'd2:    seg7 = 7'b1011011;
            4'd3:    seg7 = 7'b1001111;
            4'd4:    seg7 = 7'b1100110;
            4'd5:    seg7 = 7'b1101101;
            4'd6:    seg7 = 7'b1111101;
            4'd7:    seg7 = 7'b0000111;
            4'd8:    seg7 = 7'b1111111;
            4'd9:    seg7 = 7'b1101111;
            default: seg7 = 7'b0000000;
        endcase
    endfunction

    logic [7*DIGITS-1:0] seg_nxt;

    always_comb begin
        seg_nxt = '0;
        for (int i = 0; i < DIGITS; i++)
            seg_nxt[7*i +: 7] = seg7(shift_full[IN_W + 4*i +: 4]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    seg_out <= {DIGITS{7'b0111111}};
        else if (last) seg_out <= seg_nxt;
    end
`endif

    // Datapath: bcd_out only changes on the final shift, so it never shows a partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            binreg  <= '0;
            scratch <= '0;
            cnt     <= '0;
            bcd_out <= '0;
        end else if (accept) begin
            binreg  <= bin_in;
            scratch <= '0;
            cnt     <= '0;
        end else if (state == S_SHIFT) begin
            binreg  <= shift_full[IN_W-1:0];
            scratch <= shift_full[BCD_W+IN_W-1:IN_W];
            cnt     <= cnt + 1'b1;
            if (last) bcd_out <= shift_full[BCD_W+IN_W-1:IN_W];
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq (default parameters: 7-bit input, 3 digits).
// Seg checks are compiled in when BCD_SEG_EN is defined for both bench and RTL.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  bin_in = '0;
    logic        busy;
    logic        done;
    logic [11:0] bcd_out;
`ifdef BCD_SEG_EN
    logic [20:0] seg_out;
`endif

    int total  = 0;
    int passed = 0;

    bin2bcd_seq #(.IN_W(7), .DIGITS(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out)
`ifdef BCD_SEG_EN
        ,
        .seg_out (seg_out)
`endif
    );

    always #5 clk = ~clk;

    // Called 1 time unit after a rising edge while the DUT is not busy; returns at the same offset.
    task automatic do_accept(input logic [6:0] v);
        start  = 1'b1;
        bin_in = v;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    // Bounded wait: returns cycles elapsed until done is seen (or the budget of 30 expires).
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!done && cyc < 30);
    endtask

    task automatic test_reset;
        #12;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
        total++; if (bcd_out !== 12'h000) $display("FAIL reset_bcd got %h want 000", bcd_out); else passed++;
`ifdef BCD_SEG_EN
        total++; if (seg_out !== {3{7'b0111111}}) $display("FAIL reset_seg got %b want all-zero glyphs", seg_out); else passed++;
`endif
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic;
        int c;
        do_accept(7'd15);
        total++; if (busy !== 1'b1) $display("FAIL basic_busy_after_accept got %b want 1", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL basic_done_after_accept got %b want 0", done); else passed++;
        wait_done(c);
        total++; if (c !== 7) $display("FAIL basic_latency got %0d want 7", c); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL basic_busy_in_done got %b want 0", busy); else passed++;
        total++; if (bcd_out !== 12'h015) $display("FAIL basic_bcd got %h want 015", bcd_out); else passed++;
        @(posedge clk);
        #1;
        total++; if (done !== 1'b0) $display("FAIL basic_done_pulse_width got %b want 0", done); else passed++;
        total++; if (bcd_out !== 12'h015) $display("FAIL basic_bcd_hold got %h want 015", bcd_out); else passed++;
    endtask

    task automatic test_back_to_back;
        int c1, c2;
        do_accept(7'd75);
        wait_done(c1);
        total++; if (c1 !== 7) $display("FAIL b2b_first_latency got %0d want 7", c1); else passed++;
        total++; if (bcd_out !== 12'h075) $display("FAIL b2b_first_bcd got %h want 075", bcd_out); else passed++;
        do_accept(7'd18);
        total++; if (busy !== 1'b1) $display("FAIL b2b_accept_in_done got busy %b want 1", busy); else passed++;
        wait_done(c2);
        total++; if (c2 + 1 !== 8) $display("FAIL b2b_done_spacing got %0d want 8", c2 + 1); else passed++;
        total++; if (bcd_out !== 12'h018) $display("FAIL b2b_second_bcd got %h want 018", bcd_out); else passed++;
        @(posedge clk);
        #1;
        total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL b2b_idle_after got done=%b busy=%b want 0 0", done, busy); else passed++;
    endtask

    task automatic test_boundaries;
        logic [6:0]  vals [3] = '{7'd0, 7'd127, 7'd105};
        logic [11:0] exps [3] = '{12'h000, 12'h127, 12'h105};
        int c;
        for (int i = 0; i < 3; i++) begin
            do_accept(vals[i]);
            wait_done(c);
            total++; if (c !== 7) $display("FAIL bound_latency_%0d got %0d want 7", vals[i], c); else passed++;
            total++; if (bcd_out !== exps[i]) $display("FAIL bound_bcd_%0d got %h want %h", vals[i], bcd_out, exps[i]); else passed++;
            @(posedge clk);
            #1;
        end
    endtask

`ifdef BCD_SEG_EN
    task automatic test_seg;
        logic [20:0] pat75 = {7'b0111111, 7'b0000111, 7'b1101101};
        do_accept(7'd75);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        total++; if (done !== 1'b0 || seg_out === pat75) $display("FAIL seg_before_done got done=%b seg=%b want 0 and old glyphs", done, seg_out); else passed++;
        @(posedge clk);
        #1;
        total++; if (done !== 1'b1) $display("FAIL seg_done got %b want 1", done); else passed++;
        total++; if (seg_out !== pat75) $display("FAIL seg_75 got %b want %b", seg_out, pat75); else passed++;
        @(posedge clk);
        #1;
    endtask
`endif

    task automatic test_busy_ignore;
        int n_done = 0;
        logic [11:0] cap = 12'hfff;
        do_accept(7'd45);
        @(posedge clk);
        #1;
        start  = 1'b1;
        bin_in = 7'd99;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) begin
                n_done++;
                cap = bcd_out;
            end
        end
        total++; if (n_done !== 1) $display("FAIL ignore_done_count got %0d want 1", n_done); else passed++;
        total++; if (cap !== 12'h045) $display("FAIL ignore_bcd got %h want 045", cap); else passed++;
    endtask

    task automatic test_reset_abort;
        int n_done = 0;
        int c;
        do_accept(7'd100);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL abort_done got %b want 0", done); else passed++;
        total++; if (bcd_out !== 12'h000) $display("FAIL abort_bcd got %h want 000", bcd_out); else passed++;
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        total++; if (n_done !== 0) $display("FAIL abort_spurious_done got %0d want 0", n_done); else passed++;
        do_accept(7'd9);
        wait_done(c);
        total++; if (c !== 7) $display("FAIL abort_restart_latency got %0d want 7", c); else passed++;
        total++; if (bcd_out !== 12'h009) $display("FAIL abort_restart_bcd got %h want 009", bcd_out); else passed++;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_back_to_back;
        test_boundaries;
`ifdef BCD_SEG_EN
        test_seg;
`endif
        test_busy_ignore;
        test_reset_abort;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
